// File: rtl/trivium_pkg.sv
// Shared constants and the loader state type for the Trivium key/IV loader.
// Optional feature macro used by the loader: TRIVIUM_LOADER_IV_REKEY_EN.
package trivium_pkg;

  localparam int KEY_BYTES      = 10;
  localparam int IV_BYTES       = 10;
  localparam int WARMUP_DEFAULT = 1152;
  localparam int KV_WIDTH       = 80;
  localparam int BYTE_CNT_W     = 4;
  localparam int WARM_CNT_W     = 12;

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_IV  = 2'd1,
    WARMUP   = 2'd2,
    RUN      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/trivium_warmup_ctr.sv
// Warm-up counter: a start pulse marks the first warm-up cycle; done rises
// in the last warm-up cycle so the loader can enter RUN on the following edge.
// Once done it holds until cleared or restarted.
module trivium_warmup_ctr
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic start,
  output logic done
);

  localparam logic [WARM_CNT_W-1:0] LAST = 12'(WARMUP_CYCLES - 1);

  logic [WARM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  active_q, active_d;

  // Next count: clear wins, start counts its own cycle, then count up to LAST
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start) begin
      cnt_d    = 12'd1;
      active_d = 1'b1;
    end else if (active_q && (cnt_q < LAST)) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  // Done level; with a one-cycle warm-up the start cycle is also the last one
  always_comb begin
    done = 1'b0;
    if (!clear) begin
      if (start) begin
        done = (LAST == '0);
      end else begin
        done = active_q && (cnt_q >= LAST);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/trivium_loader.sv
// Byte-serial key/IV loader for a Trivium cipher core: collects 10 key bytes
// and 10 IV bytes, pulses trv_load, waits out the warm-up, then flags
// ks_valid. Define TRIVIUM_LOADER_IV_REKEY_EN to accept a fresh IV while in
// RUN without reloading the key.
module trivium_loader
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                restart,
  output logic [KV_WIDTH-1:0] key,
  output logic [KV_WIDTH-1:0] iv,
  output logic                trv_load,
  output logic                ks_valid
);

  localparam logic [BYTE_CNT_W-1:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] IV_LAST  = 4'(IV_BYTES - 1);

  loader_state_e             state_q, state_d;
  logic [BYTE_CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [KV_WIDTH-1:0]       key_q, key_d;
  logic [KV_WIDTH-1:0]       iv_q, iv_d;
  logic                      trv_load_q, trv_load_d;
  logic                      take;
  logic                      warm_done;

  assign take = data_valid && data_ready;

  trivium_warmup_ctr #(
    .WARMUP_CYCLES(WARMUP_CYCLES)
  ) u_warmup_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(restart),
    .start(trv_load_q),
    .done (warm_done)
  );

  // State and byte-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_KEY;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next state: restart overrides everything, including a same-cycle transfer
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    if (restart) begin
      state_d    = LOAD_KEY;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        LOAD_KEY: begin
          if (take) begin
            if (byte_cnt_q == KEY_LAST) begin
              state_d    = LOAD_IV;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
        LOAD_IV: begin
          if (take) begin
            if (byte_cnt_q == IV_LAST) begin
              state_d    = WARMUP;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
        end
        WARMUP: begin
          if (warm_done) begin
            state_d = RUN;
          end
        end
        RUN: begin
`ifdef TRIVIUM_LOADER_IV_REKEY_EN
          if (take) begin
            state_d    = LOAD_IV;
            byte_cnt_d = 4'd1;
          end
`endif
        end
        default: begin
          state_d    = LOAD_KEY;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    data_ready = (state_q == LOAD_KEY) || (state_q == LOAD_IV);
`ifdef TRIVIUM_LOADER_IV_REKEY_EN
    if (state_q == RUN) begin
      data_ready = 1'b1;
    end
`endif
    ks_valid = (state_q == RUN);
    trv_load = trv_load_q;
    key      = key_q;
    iv       = iv_q;
  end

  // Shift accepted bytes into key/IV and raise the load pulse on the last IV byte
  always_comb begin
    key_d      = key_q;
    iv_d       = iv_q;
    trv_load_d = 1'b0;
    if (!restart && take) begin
      if (state_q == LOAD_KEY) begin
        key_d = {key_q[KV_WIDTH-9:0], data_in};
      end
      if ((state_q == LOAD_IV) || (state_q == RUN)) begin
        iv_d = {iv_q[KV_WIDTH-9:0], data_in};
      end
      trv_load_d = (state_q == LOAD_IV) && (byte_cnt_q == IV_LAST);
    end
  end

  // Key, IV and load-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      iv_q       <= '0;
      trv_load_q <= 1'b0;
    end else begin
      key_q      <= key_d;
      iv_q       <= iv_d;
      trv_load_q <= trv_load_d;
    end
  end

endmodule

// File: tb/tb_trivium_loader.sv
// Directed bench for trivium_loader: instance A uses the default 1152-cycle
// warm-up, instance B uses an 8-cycle warm-up. Inputs change on the falling
// edge and outputs are checked on the falling edge.
module tb_trivium_loader;

  logic        clk;
  logic        a_rst_n, a_valid, a_restart;
  logic [7:0]  a_data;
  logic        a_ready, a_trv, a_ks;
  logic [79:0] a_key, a_iv;
  logic        b_rst_n, b_valid, b_restart;
  logic [7:0]  b_data;
  logic        b_ready, b_trv, b_ks;
  logic [79:0] b_key, b_iv;

  int total;
  int bad;
  int trv_a;
  int trv_b;

  trivium_loader u_dut_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .data_in   (a_data),
    .data_valid(a_valid),
    .data_ready(a_ready),
    .restart   (a_restart),
    .key       (a_key),
    .iv        (a_iv),
    .trv_load  (a_trv),
    .ks_valid  (a_ks)
  );

  trivium_loader #(
    .WARMUP_CYCLES(8)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .data_in   (b_data),
    .data_valid(b_valid),
    .data_ready(b_ready),
    .restart   (b_restart),
    .key       (b_key),
    .iv        (b_iv),
    .trv_load  (b_trv),
    .ks_valid  (b_ks)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count trv_load pulses seen by each instance
  initial begin
    trv_a = 0;
    trv_b = 0;
  end
  always @(posedge clk) begin
    if (a_trv) trv_a <= trv_a + 1;
    if (b_trv) trv_b <= trv_b + 1;
  end

  // Drive one instance for one clock, returning on the next falling edge
  task automatic applyStimulus(input bit sel, input logic v, input logic [7:0] d, input logic r);
    if (!sel) begin
      a_valid   = v;
      a_data    = d;
      a_restart = r;
    end else begin
      b_valid   = v;
      b_data    = d;
      b_restart = r;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int t0;
    int ks_hits;
    int trv_hits;
    total     = 0;
    bad       = 0;
    a_rst_n   = 1'b0;
    b_rst_n   = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = 8'h00;
    b_data    = 8'h00;
    a_restart = 1'b0;
    b_restart = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_key", a_key, 80'h0);
    checkOutput("rst_iv", a_iv, 80'h0);
    checkOutput("rst_trv", a_trv, 80'h0);
    checkOutput("rst_ks", a_ks, 80'h0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    checkOutput("rst_ready_a", a_ready, 80'h1);
    checkOutput("rst_ready_b", b_ready, 80'h1);

    // A: 20 bytes back-to-back, then the full warm-up
    $display("[TB] back-to-back load with default warm-up");
    t0 = trv_a;
    for (int i = 1; i <= 20; i++) applyStimulus(0, 1'b1, 8'(i), 1'b0);
    a_valid = 1'b0;
    checkOutput("load_trv", a_trv, 80'h1);
    checkOutput("load_key", a_key, 80'h0102030405060708090A);
    checkOutput("load_iv", a_iv, 80'h0B0C0D0E0F1011121314);
    checkOutput("warm_ready", a_ready, 80'h0);
    checkOutput("warm_ks0", a_ks, 80'h0);
    for (int i = 1; i <= 1152; i++) begin
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      if (i == 1) checkOutput("trv_single", a_trv, 80'h0);
      if (i == 1151) checkOutput("ks_early", a_ks, 80'h0);
      if (i == 1152) checkOutput("ks_on_time", a_ks, 80'h1);
    end
    checkOutput("trv_count_a", 80'(trv_a - t0), 80'h1);

    // A: ten 0xAA bytes offered while in RUN
    t0 = trv_a;
`ifdef TRIVIUM_LOADER_IV_REKEY_EN
    checkOutput("run_ready", a_ready, 80'h1);
    applyStimulus(0, 1'b1, 8'hAA, 1'b0);
    checkOutput("rekey_ks_drop", a_ks, 80'h0);
    checkOutput("rekey_ready", a_ready, 80'h1);
    for (int i = 2; i <= 10; i++) applyStimulus(0, 1'b1, 8'hAA, 1'b0);
    a_valid = 1'b0;
    checkOutput("rekey_trv", a_trv, 80'h1);
    checkOutput("rekey_iv", a_iv, 80'hAAAAAAAAAAAAAAAAAAAA);
    checkOutput("rekey_key", a_key, 80'h0102030405060708090A);
`else
    checkOutput("run_ready", a_ready, 80'h0);
    for (int i = 1; i <= 10; i++) applyStimulus(0, 1'b1, 8'hAA, 1'b0);
    a_valid = 1'b0;
    checkOutput("run_ks_hold", a_ks, 80'h1);
    checkOutput("run_key_hold", a_key, 80'h0102030405060708090A);
    checkOutput("run_iv_hold", a_iv, 80'h0B0C0D0E0F1011121314);
    checkOutput("run_no_trv", 80'(trv_a - t0), 80'h0);
`endif

    // A: restart, reload, then asynchronous reset mid warm-up
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    a_restart = 1'b0;
    checkOutput("restart_ks", a_ks, 80'h0);
    checkOutput("restart_ready", a_ready, 80'h1);
    checkOutput("restart_trv", a_trv, 80'h0);
    checkOutput("restart_key_kept", a_key, 80'h0102030405060708090A);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1'b1, 8'(8'h41 + i), 1'b0);
    a_valid = 1'b0;
    checkOutput("reload_trv", a_trv, 80'h1);
    checkOutput("reload_key", a_key, 80'h4142434445464748494A);
    for (int i = 1; i <= 500; i++) applyStimulus(0, 1'b0, 8'h00, 1'b0);
    #2 a_rst_n = 1'b0;
    #1;
    checkOutput("async_key", a_key, 80'h0);
    checkOutput("async_iv", a_iv, 80'h0);
    checkOutput("async_trv", a_trv, 80'h0);
    checkOutput("async_ks", a_ks, 80'h0);
    @(negedge clk);
    a_rst_n = 1'b1;
    checkOutput("post_rst_ready", a_ready, 80'h1);
    t0 = trv_a;
    ks_hits = 0;
    trv_hits = 0;
    for (int i = 1; i <= 1200; i++) begin
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
      if (a_ks) ks_hits++;
      if (a_trv) trv_hits++;
    end
    checkOutput("post_rst_no_ks", 80'(ks_hits), 80'h0);
    checkOutput("post_rst_no_trv", 80'(trv_hits + trv_a - t0), 80'h0);

    // B: data_valid toggling every cycle, then held high through warm-up
    $display("[TB] toggled valid with short warm-up");
    t0 = trv_b;
    for (int i = 0; i <= 38; i++) applyStimulus(1, (i % 2) == 0, 8'(8'h30 + i), 1'b0);
    checkOutput("tog_trv", b_trv, 80'h1);
    checkOutput("tog_key", b_key, 80'h30323436383A3C3E4042);
    checkOutput("tog_iv", b_iv, 80'h4446484A4C4E50525456);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1'b1, 8'hEE, 1'b0);
      if (i == 1) checkOutput("hold_trv_low", b_trv, 80'h0);
      if (i == 7) checkOutput("short_ks_early", b_ks, 80'h0);
      if (i == 8) checkOutput("short_ks_on_time", b_ks, 80'h1);
    end
    b_valid = 1'b0;
    checkOutput("hold_key", b_key, 80'h30323436383A3C3E4042);
    checkOutput("hold_iv", b_iv, 80'h4446484A4C4E50525456);
    checkOutput("hold_trv_count", 80'(trv_b - t0), 80'h1);

    // B: restart together with the 5th IV byte
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 8'(8'h70 + i), 1'b0);
    applyStimulus(1, 1'b1, 8'h74, 1'b1);
    b_restart = 1'b0;
    b_valid   = 1'b0;
    checkOutput("abort_ready", b_ready, 80'h1);
    checkOutput("abort_trv", b_trv, 80'h0);
    checkOutput("abort_ks", b_ks, 80'h0);
    checkOutput("abort_key", b_key, 80'h60616263646566676869);
    checkOutput("abort_iv", b_iv, 80'h4C4E5052545670717273);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1'b1, 8'(8'h80 + i), 1'b0);
    checkOutput("relo_ready", b_ready, 80'h1);
    checkOutput("relo_trv_low", b_trv, 80'h0);
    checkOutput("relo_key", b_key, 80'h80818283848586878889);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1'b1, 8'(8'h90 + i), 1'b0);
    b_valid = 1'b0;
    checkOutput("relo_trv", b_trv, 80'h1);
    checkOutput("relo_iv", b_iv, 80'h90919293949596979899);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trivium_loader.md
TRIVIUM_LOADER -- requirements
Module: trivium_loader

Interface
REQ-001 Parameter: WARMUP_CYCLES, default 1152, number of cipher warm-up cycles after each load (4 x 288); legal range 1..4095.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8  key/IV byte.
REQ-005 data_valid  input  1  data_in holds a byte offered for transfer.
REQ-006 data_ready  output  1  loader can accept a byte this cycle.
REQ-007 restart  input  1  synchronous abort; return to key loading.
REQ-008 key  output  80  assembled key to cipher core.
REQ-009 iv  output  80  assembled IV to cipher core.
REQ-010 trv_load  output  1  one-cycle pulse; cipher core reloads key/IV.
REQ-011 ks_valid  output  1  cipher core keystream is past warm-up and usable.

Function
REQ-012 States SHALL be LOAD_KEY, LOAD_IV, WARMUP, RUN; byte counter 0..9; warm-up counter 12 bits.
REQ-013 A transfer SHALL occur on a rising edge with data_valid=1 and data_ready=1; data_ready SHALL be 1 only in LOAD_KEY and LOAD_IV.
REQ-014 In LOAD_KEY each transfer SHALL shift key <= {key[71:0], data_in}; the first byte ends in key[79:72].
REQ-015 The 10th key transfer SHALL clear the byte counter and enter LOAD_IV; key SHALL then hold its value.
REQ-016 In LOAD_IV each transfer SHALL shift iv <= {iv[71:0], data_in}; the 10th transfer SHALL enter WARMUP.
REQ-017 trv_load SHALL be 1 for exactly the first cycle spent in WARMUP; key and iv SHALL be stable from that cycle until the next load starts.
REQ-018 If trv_load is high in cycle N, ks_valid SHALL first be high in cycle N+WARMUP_CYCLES, entering RUN.
REQ-019 In RUN ks_valid SHALL stay 1; data_valid SHALL be ignored unless REQ-025 applies.
REQ-020 restart=1 in any state SHALL on the next edge enter LOAD_KEY, clear byte and warm-up counters, drive ks_valid=0, trv_load=0; key and iv retain values until overwritten.
REQ-021 restart takes priority over a simultaneous transfer; that byte SHALL be discarded.
REQ-022 data_valid without data_ready (WARMUP, RUN) SHALL not change any state.

Reset
REQ-023 rst_n=0 SHALL immediately force: state LOAD_KEY, counters 0, key=0, iv=0, trv_load=0, ks_valid=0, data_ready=1 once rst_n deasserts.
REQ-024 Reset asserted mid-load or mid-warm-up SHALL discard partial progress; no trv_load pulse SHALL be issued for an incomplete load.

Configuration
REQ-025 With TRIVIUM_LOADER_IV_REKEY_EN defined: data_ready=1 also in RUN; a transfer in RUN SHALL drop ks_valid on the next edge, enter LOAD_IV with the byte taken as IV byte 1 (byte counter 1), keeping key unchanged.
REQ-026 Without TRIVIUM_LOADER_IV_REKEY_EN: data_ready=0 in RUN; only restart or reset leave RUN.

Structure
REQ-027 Package trivium_pkg SHALL hold the state enum, KEY_BYTES=10, IV_BYTES=10, WARMUP_DEFAULT=1152 and the 80-bit key/IV width constant.
REQ-028 One sub-module trivium_warmup_ctr SHALL implement the warm-up counter (start pulse in, done level out, parameter WARMUP_CYCLES).

Verification
REQ-029 Reset then 20 bytes 0x01..0x14 back-to-back -> key=0x0102..0A, iv=0x0B0C..14, one trv_load pulse in cycle after byte 20, ks_valid exactly 1152 cycles after trv_load.
REQ-030 WARMUP_CYCLES=8, data_valid toggled 1/0 every cycle -> only handshaked bytes shifted, ks_valid 8 cycles after trv_load.
REQ-031 restart asserted together with 5th IV byte -> byte discarded, state LOAD_KEY, no trv_load, ks_valid=0.
REQ-032 rst_n pulsed low during WARMUP (cycle 500 of 1152) -> all outputs zero asynchronously, no ks_valid afterwards until full reload.
REQ-033 In RUN, 10 bytes 0xAA offered -> with TRIVIUM_LOADER_IV_REKEY_EN: ks_valid drops, iv=0xAA..AA, key unchanged, new trv_load; without: data_ready=0, nothing changes.
REQ-034 data_valid held 1 during WARMUP with WARMUP_CYCLES=8 -> key/iv unchanged, single trv_load only.
